// File: rtl/sqrt_scheduler.sv
// sqrt_scheduler: round-robin arbiter sharing one iterative fixed-point sqrt unit among N_REQ requesters.
// Latency: accept at cycle t -> o_rsp_valid at t+ITER+3; at most one job every ITER+4 cycles.
// Backpressure: o_rsp_* held while !i_rsp_ready; no grant until the handshake completes and the unit is idle.
// Optional watchdog: define SQRT_WDOG_EN to time out a stuck unit (o_rsp_err=1, zero root/remainder).
module sqrt_scheduler #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 32,
  parameter int FRACT_BITS = 32,
  parameter int WDOG_LIMIT = (WIDTH + FRACT_BITS) / 2 + 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*WIDTH-1:0]     i_req_rad,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   o_rsp_id,
  output logic [WIDTH-1:0]           o_rsp_root,
  output logic [WIDTH-1:0]           o_rsp_rem,
  output logic                       o_rsp_err,
  output logic                       o_sqrt_start,
  output logic [WIDTH-1:0]           o_sqrt_rad,
  input  logic                       i_sqrt_busy,
  input  logic                       i_sqrt_valid,
  input  logic [WIDTH-1:0]           i_sqrt_root,
  input  logic [WIDTH-1:0]           i_sqrt_rem
);

  localparam int ITER = (WIDTH + FRACT_BITS) / 2;
  localparam int IDW  = $clog2(N_REQ);

  // Reject parameter sets the arbiter and unit cannot support.
  if (N_REQ < 2 || N_REQ > 16 || ITER < 1 || WDOG_LIMIT < 1) begin : g_bad_cfg
    $error("sqrt_scheduler: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic             sqrt_start_q;
  logic [WIDTH-1:0] sqrt_rad_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_root_q;
  logic [WIDTH-1:0] rsp_rem_q;

`ifdef SQRT_WDOG_EN
  localparam int WDW = $clog2(WDOG_LIMIT + 1);
  logic [WDW-1:0]   wdog_q;
  logic             rsp_err_q;
`endif

  logic [WIDTH-1:0] rad_arr [N_REQ];
  logic [N_REQ-1:0] grant_d;
  logic [IDW-1:0]   grant_id_d;
  logic             grant_found;
  logic [IDW:0]     cand_sum;
  logic [IDW-1:0]   cand_idx;
  logic [N_REQ-1:0] req_ready_d;
  logic             accept_d;
  logic             sqrt_done;

  for (genvar g = 0; g < N_REQ; g++) begin : g_rad
    assign rad_arr[g] = i_req_rad[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first valid requester after the last served one, wrapping around.
  always_comb begin
    grant_d     = '0;
    grant_id_d  = '0;
    grant_found = 1'b0;
    cand_sum    = '0;
    cand_idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand_sum >= (IDW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IDW+1)'(N_REQ);
      end
      cand_idx = cand_sum[IDW-1:0];
      if (!grant_found && i_req_valid[cand_idx]) begin
        grant_found        = 1'b1;
        grant_d[cand_idx]  = 1'b1;
        grant_id_d         = cand_idx;
      end
    end
  end

  // Offer a grant only in IDLE and only once the unit (which has no reset) is idle.
  assign req_ready_d = (state_q == S_IDLE && !i_sqrt_busy && !i_reset) ? grant_d : '0;
  assign accept_d    = |(i_req_valid & req_ready_d);
  assign sqrt_done   = i_sqrt_valid && !i_sqrt_busy;

  // Scheduler FSM: grant, launch the unit, wait for its result, present the response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= IDW'(N_REQ - 1);
      id_q         <= '0;
      sqrt_start_q <= 1'b0;
      sqrt_rad_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_root_q   <= '0;
      rsp_rem_q    <= '0;
`ifdef SQRT_WDOG_EN
      wdog_q       <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            sqrt_rad_q   <= rad_arr[grant_id_d];
            sqrt_start_q <= 1'b1;
            id_q         <= grant_id_d;
            ptr_q        <= grant_id_d;
            state_q      <= S_START;
          end
        end
        S_START: begin
          // The unit clears its sticky valid on this edge, so WAIT never sees a stale result.
          sqrt_start_q <= 1'b0;
`ifdef SQRT_WDOG_EN
          wdog_q       <= '0;
`endif
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (sqrt_done) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_root_q  <= i_sqrt_root;
            rsp_rem_q   <= i_sqrt_rem;
`ifdef SQRT_WDOG_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= S_RESP;
          end
`ifdef SQRT_WDOG_EN
          else if (wdog_q == WDW'(WDOG_LIMIT - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_root_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wdog_q <= wdog_q + WDW'(1);
          end
`endif
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = req_ready_d;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_root   = rsp_root_q;
  assign o_rsp_rem    = rsp_rem_q;
  assign o_sqrt_start = sqrt_start_q;
  assign o_sqrt_rad   = sqrt_rad_q;
`ifdef SQRT_WDOG_EN
  assign o_rsp_err    = rsp_err_q;
`else
  assign o_rsp_err    = 1'b0;
`endif

endmodule

// File: doc/sqrt_scheduler.md
Name: sqrt_scheduler

Overview:
- Shares one iterative fixed-point square_root datapath (start/busy/valid interface, ITER = (WIDTH+FRACT_BITS)/2 iterations) between N_REQ requesters using round-robin arbitration.
- Grants one requester, registers its radicand, pulses the unit's start, waits for completion, then returns root/remainder tagged with the requester id over a valid/ready response channel.
- Sits between the pricing/volatility engines and the shared sqrt unit.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 32, radicand/root/remainder width; must match the sqrt unit.
- FRACT_BITS, 32, fractional bits; must match the sqrt unit. Local ITER = (WIDTH+FRACT_BITS)/2.
- WDOG_LIMIT, ITER+8, watchdog timeout in cycles; used only with SQRT_WDOG_EN.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_req_valid  in  N_REQ  per-requester request valid
- i_req_rad  in  N_REQ*WIDTH  radicands; requester k occupies bits [k*WIDTH +: WIDTH]
- o_req_ready  out  N_REQ  one-hot accept; request k is accepted when valid[k]&&ready[k]
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response accept
- o_rsp_id  out  $clog2(N_REQ)  id of the served requester
- o_rsp_root  out  WIDTH  root
- o_rsp_rem  out  WIDTH  remainder
- o_rsp_err  out  1  watchdog timeout flag
- o_sqrt_start  out  1  registered start pulse to the sqrt unit
- o_sqrt_rad  out  WIDTH  registered radicand to the sqrt unit
- i_sqrt_busy  in  1  sqrt unit busy
- i_sqrt_valid  in  1  sqrt unit result valid; sticky until the next start
- i_sqrt_root  in  WIDTH  root from the sqrt unit
- i_sqrt_rem  in  WIDTH  remainder from the sqrt unit

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer = N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE
  - o_req_ready is combinational: one-hot on the first valid requester searching from pointer+1 with wrap-around. It is nonzero only when i_sqrt_busy==0.
  - On accept: o_sqrt_rad<=rad[k], o_sqrt_start<=1, id<=k, pointer<=k, go to START.
  - With no valid requesters, stay in IDLE.
- START: o_sqrt_start<=0; go to WAIT. Start is high for exactly one cycle.
- WAIT
  - Leave on i_sqrt_valid && !i_sqrt_busy: capture root/rem into o_rsp_root/o_rsp_rem, set o_rsp_valid<=1, go to RESP.
  - Sticky valid from a previous job cannot false-trigger because the unit clears valid on the start edge, before the WAIT state's first cycle.
- RESP
  - Hold all o_rsp_* stable while o_rsp_valid && !i_rsp_ready.
  - On handshake: o_rsp_valid<=0, go to IDLE.
  - A new grant is earliest in the cycle after the handshake.
- Latency: request accepted at cycle t gives o_rsp_valid at cycle t+ITER+3 (35 for the defaults) with i_rsp_ready held high.
- Throughput: one job per ITER+4 cycles minimum.
- Fairness: a requester holding valid waits at most N_REQ-1 jobs.
- Requester changes i_req_valid or rad while not granted: no effect, no latching.
- Reset mid-operation: FSM returns to IDLE and any in-flight result is discarded. The sqrt unit has no reset and may still be busy, so IDLE must not grant while i_sqrt_busy==1.
- Reset asserted while o_rsp_valid is high: response dropped, o_rsp_valid=0 immediately (asynchronous).

Optional Feature:
- Macro: SQRT_WDOG_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches WDOG_LIMIT without completion, go to RESP with o_rsp_err=1, o_rsp_root=0, o_rsp_rem=0, o_rsp_id = the served id.
  - The next IDLE still waits for !i_sqrt_busy.
- Undefined: no counter; o_rsp_err tied to 0; WAIT waits indefinitely.

Test Plan:
- Single request: req0 rad=121 (raw), defaults, i_rsp_ready=1 -> one start pulse at t+1; o_rsp_valid at t+35 with id=0, root=0x000B0000, rem=0.
- Second value: req2 rad=2 -> root=0x00016A09 (92681), rem=166831, id=2.
- Round-robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0; each response id matches its grant; no requester is served twice before all others are served once.
- Back-pressure: i_rsp_ready=0 for 10 cycles at response -> outputs stable, no new start pulse, o_req_ready=0; response completes on the ready cycle, next grant the cycle after.
- Reset mid-WAIT: i_reset pulsed 5 cycles after start while the unit is still busy -> outputs go to 0; no grant until i_sqrt_busy falls; next request yields a correct result.
- With SQRT_WDOG_EN: sqrt model never asserts valid, WDOG_LIMIT=40 -> o_rsp_valid 40 cycles after WAIT entry, o_rsp_err=1, root=rem=0.
